// File: rtl/c17_test_pkg.sv
// c17_test_pkg: shared FSM state type, widths and c17 pin bit positions
package c17_test_pkg;
  typedef enum logic [1:0] {IDLE, APPLY, SAMPLE, DONE} state_t;
  localparam int PAT_W = 5;
  localparam int RESP_W = 2;
  localparam int NUM_PAT = 32;
  localparam int B_N1 = 4;
  localparam int B_N2 = 3;
  localparam int B_N3 = 2;
  localparam int B_N6 = 1;
  localparam int B_N7 = 0;
  localparam int R_N22 = 1;
  localparam int R_N23 = 0;
endpackage

// File: rtl/c17_golden_model.sv
// c17_golden_model: combinational c17 reference; pat_i {N1,N2,N3,N6,N7} -> resp_o {N22,N23}
module c17_golden_model
  import c17_test_pkg::*;
(
  input  logic [PAT_W-1:0]  pat_i,
  output logic [RESP_W-1:0] resp_o
);
  logic n10, n11, n16, n19;
  always_comb begin
    n10 = ~(pat_i[B_N1] & pat_i[B_N3]);
    n11 = ~(pat_i[B_N3] & pat_i[B_N6]);
    n16 = ~(pat_i[B_N2] & n11);
    n19 = ~(n11 & pat_i[B_N7]);
    resp_o = '0;
    resp_o[R_N22] = ~(n10 & n16);
    resp_o[R_N23] = ~(n16 & n19);
  end
endmodule

// File: rtl/c17_pattern_tester.sv
// c17_pattern_tester: exhaustive c17 tester; clk/rst/start in, pat_o to CUT, resp_i from CUT, busy/done/pass/fail_count/first_fail out
module c17_pattern_tester
  import c17_test_pkg::*;
#(
  parameter int SETTLE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [PAT_W-1:0]  pat_o,
  input  logic [RESP_W-1:0] resp_i,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [5:0]        fail_count,
  output logic [PAT_W-1:0]  first_fail
);
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [PAT_W-1:0] pat_q, pat_d, first_q, first_d;
  logic [5:0] fail_q, fail_d;
  logic pass_q, pass_d;
  logic [RESP_W-1:0] exp_resp;
  logic miss, last;
  c17_golden_model u_gold (.pat_i(pat_q), .resp_o(exp_resp));
  assign miss = exp_resp != resp_i;
  assign last = pat_q == PAT_W'(NUM_PAT - 1);
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    pat_d = pat_q;
    fail_d = fail_q;
    first_d = first_q;
    pass_d = pass_q;
    case (state_q)
      IDLE, DONE: if (start) begin
        state_d = APPLY;
        cnt_d = '0;
        pat_d = '0;
        fail_d = '0;
        first_d = '0;
        pass_d = 1'b0;
      end
      APPLY: begin
        state_d = (cnt_q == 4'(SETTLE - 1)) ? SAMPLE : APPLY;
        cnt_d = (cnt_q == 4'(SETTLE - 1)) ? 4'd0 : cnt_q + 4'd1;
      end
      SAMPLE: begin
        fail_d = fail_q + 6'(miss);
        first_d = (miss && fail_q == 6'd0) ? pat_q : first_q;
        state_d = last ? DONE : APPLY;
        pat_d = last ? pat_q : pat_q + PAT_W'(1);
        pass_d = last && fail_d == 6'd0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      pat_q <= '0;
      fail_q <= '0;
      first_q <= '0;
      pass_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      pat_q <= pat_d;
      fail_q <= fail_d;
      first_q <= first_d;
      pass_q <= pass_d;
    end
  end
  assign pat_o = pat_q;
  assign busy = state_q == APPLY || state_q == SAMPLE;
  assign done = state_q == DONE;
  assign pass = pass_q;
  assign fail_count = fail_q;
  assign first_fail = first_q;
endmodule

// File: tb/tb_c17_pattern_tester.sv
// tb_c17_pattern_tester: directed self-checking bench for c17_pattern_tester
module tb_c17_pattern_tester;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, start3 = 1'b0;
  logic [4:0] pat_o, first_fail, pat3, first3, gpat;
  logic [1:0] resp_i, resp3, gresp;
  logic busy, done, pass, busy3, done3, pass3;
  logic [5:0] fail_count, fail3;
  int mode = 0;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  function automatic logic [1:0] c17(input logic [4:0] p);
    logic n10, n11, n16, n19;
    n10 = ~(p[4] & p[2]);
    n11 = ~(p[2] & p[1]);
    n16 = ~(p[3] & n11);
    n19 = ~(n11 & p[0]);
    return {~(n10 & n16), ~(n16 & n19)};
  endfunction
  always_comb begin
    resp_i = c17(pat_o);
    if (mode == 1) resp_i[1] = 1'b0;
    if (mode == 2) resp_i[0] = 1'b1;
    if (mode == 3 && pat_o == 5'd17) resp_i = ~c17(pat_o);
  end
  assign resp3 = c17(pat3);
  c17_pattern_tester #(.SETTLE(1)) dut (
    .clk(clk), .rst(rst), .start(start), .pat_o(pat_o), .resp_i(resp_i),
    .busy(busy), .done(done), .pass(pass), .fail_count(fail_count), .first_fail(first_fail));
  c17_pattern_tester #(.SETTLE(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .pat_o(pat3), .resp_i(resp3),
    .busy(busy3), .done(done3), .pass(pass3), .fail_count(fail3), .first_fail(first3));
  c17_golden_model gold (.pat_i(gpat), .resp_o(gresp));
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, ".pat"}, int'(pat_o), 0);
    chk({tag, ".busy"}, int'(busy), 0);
    chk({tag, ".done"}, int'(done), 0);
    chk({tag, ".pass"}, int'(pass), 0);
    chk({tag, ".fail"}, int'(fail_count), 0);
    chk({tag, ".first"}, int'(first_fail), 0);
  endtask
  task automatic run(input string tag, input int pulse_at);
    int bc;
    start = 1'b1;
    tick;
    start = 1'b0;
    chk({tag, ".busy_up"}, int'(busy), 1);
    chk({tag, ".pat0"}, int'(pat_o), 0);
    chk({tag, ".cleared"}, int'(fail_count), 0);
    chk({tag, ".pass_low"}, int'(pass), 0);
    bc = 0;
    while (!done && bc < 1000) begin
      start = (bc == pulse_at);
      tick;
      bc++;
    end
    start = 1'b0;
    chk({tag, ".cycles"}, bc, 64);
    chk({tag, ".busy_dn"}, int'(busy), 0);
    chk({tag, ".pat31"}, int'(pat_o), 31);
  endtask
  initial begin
    int n23_zero, bc;
    tick;
    tick;
    rst = 1'b0;
    chk_reset("reset");
    gpat = 5'd0;  #1 chk("gold0", int'(gresp), 0);
    gpat = 5'd1;  #1 chk("gold1", int'(gresp), 1);
    gpat = 5'd8;  #1 chk("gold8", int'(gresp), 3);
    gpat = 5'd31; #1 chk("gold31", int'(gresp), 2);
    tick;
    chk("idle_hold", int'(busy), 0);
    mode = 0;
    run("good", 20);
    chk("good.pass", int'(pass), 1);
    chk("good.fail", int'(fail_count), 0);
    chk("good.first", int'(first_fail), 0);
    tick;
    tick;
    chk("done_hold", int'(done), 1);
    chk("done_hold.pass", int'(pass), 1);
    mode = 1;
    run("n22sa0", -1);
    chk("n22sa0.fail", int'(fail_count), 18);
    chk("n22sa0.first", int'(first_fail), 8);
    chk("n22sa0.pass", int'(pass), 0);
    n23_zero = 0;
    for (int i = 0; i < 32; i++) if (c17(5'(i)) ==? 2'b?0) n23_zero++;
    mode = 2;
    run("n23sa1", -1);
    chk("n23sa1.fail", int'(fail_count), n23_zero);
    chk("n23sa1.first", int'(first_fail), 0);
    chk("n23sa1.pass", int'(pass), 0);
    mode = 3;
    run("inj17", -1);
    chk("inj17.fail", int'(fail_count), 1);
    chk("inj17.first", int'(first_fail), 17);
    chk("inj17.pass", int'(pass), 0);
    mode = 1;
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int i = 0; i < 20; i++) tick;
    chk("mid.pat", int'(pat_o), 10);
    chk("mid.fail", int'(fail_count), 2);
    chk("mid.first", int'(first_fail), 8);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk_reset("midrst");
    mode = 0;
    run("clean", -1);
    chk("clean.pass", int'(pass), 1);
    chk("clean.fail", int'(fail_count), 0);
    start3 = 1'b1;
    tick;
    start3 = 1'b0;
    chk("s3.busy_up", int'(busy3), 1);
    bc = 0;
    while (!done3 && bc < 1000) begin
      tick;
      bc++;
    end
    chk("s3.cycles", bc, 128);
    chk("s3.busy_dn", int'(busy3), 0);
    chk("s3.pass", int'(pass3), 1);
    chk("s3.fail", int'(fail3), 0);
    chk("s3.first", int'(first3), 0);
    chk("s3.pat31", int'(pat3), 31);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/c17_pattern_tester.md
# c17_pattern_tester

Tester-side counterpart to the c17 benchmark circuit. It drives all 32 input patterns exhaustively onto the circuit-under-test (CUT) inputs N1, N2, N3, N6 and N7. It samples the CUT outputs N22 and N23 and compares them against an internal golden model. It reports a pass/fail verdict, the mismatch count and the first failing pattern, and sits beside the CUT in the ATPG evaluation harness.

## Interface
- SETTLE, default 1: cycles each pattern is held before sampling; legal range 1..15.
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  pulse or level; sampled only in IDLE and DONE.
- pat_o  out  5  pattern to CUT; bit4=N1, bit3=N2, bit2=N3, bit1=N6, bit0=N7; registered.
- resp_i  in  2  CUT response; bit1=N22, bit0=N23.
- busy  out  1  high in APPLY and SAMPLE.
- done  out  1  level, high in DONE.
- pass  out  1  valid while done; 1 iff fail_count==0.
- fail_count  out  6  number of mismatching patterns, 0..32.
- first_fail  out  5  index of the lowest mismatching pattern; 0 if none.

## Operation
- States: IDLE, APPLY, SAMPLE, DONE.
- IDLE:
  - On start=1, go to APPLY.
  - pat_o=0, fail_count=0, first_fail=0, settle counter=0.
- APPLY:
  - Hold pat_o and count SETTLE cycles.
  - On the SETTLE-th cycle, go to SAMPLE.
- SAMPLE:
  - Compute exp = golden(pat_o) combinationally and compare with resp_i, both bits.
  - On mismatch: fail_count+1. If this is the first mismatch (fail_count was 0), first_fail=pat_o.
  - If pat_o==31, go to DONE. Otherwise pat_o+1 and return to APPLY.
- DONE:
  - Hold all results and pat_o=31.
  - On start=1, clear results, set pat_o=0 and go to APPLY. This is a fresh run.
- start while busy is ignored.
- Golden equations:
  - N10=~(N1&N3), N11=~(N3&N6), N16=~(N2&N11), N19=~(N11&N7).
  - N22=~(N10&N16), N23=~(N16&N19).
- fail_count saturation is not needed; the maximum is 32 and fits in 6 bits.
- resp_i is treated as fully synchronous. The CUT is combinational from pat_o, and SETTLE covers its path.

## Timing
- Reset values: pat_o=0, busy=0, done=0, pass=0, fail_count=0, first_fail=0, state=IDLE.
- rst wins over every other event, including mid-run and in DONE. Return to IDLE with reset values on the next edge.
- start is sampled at edge t. busy=1 and pat_o=0 from cycle t+1.
- Per pattern: SETTLE cycles in APPLY plus 1 cycle in SAMPLE.
- done rises 32·(SETTLE+1) cycles after busy rises; this is 64 cycles at SETTLE=1. busy falls on the same edge.
- pass is registered on entry to DONE and is 0 outside DONE.
- The SAMPLE result for pattern k is visible in fail_count on the cycle after the SAMPLE cycle of pattern k.
- start held high in DONE causes an immediate restart. There is no mandatory idle cycle.

## Structure
- Package c17_test_pkg contains:
  - the state enum, with 2-bit encoding;
  - PAT_W=5, RESP_W=2, NUM_PAT=32;
  - the pattern bit-position constants for N1/N2/N3/N6/N7;
  - the response bit-position constants for N22/N23.
- Sub-module c17_golden_model: a purely combinational mapping from 5-bit pattern to 2-bit expected response using the equations above. It is reused by the bench as the scoreboard.
- The top level holds the FSM, settle counter, pattern counter and result registers.

## Test plan
- Good CUT: resp_i driven by a correct c17 instance at SETTLE=1.
  - done after 64 busy cycles.
  - pass=1, fail_count=0, first_fail=0.
- N22 stuck-at-0 (resp_i[1] tied 0): fail_count=18, first_fail=8, pass=0.
- N23 stuck-at-1 (resp_i[0] tied 1): first_fail=0, pass=0. fail_count equals the scoreboard count of patterns with N23=0.
- Spot checks with the golden model:
  - pattern 0 → 2'b00;
  - pattern 1 → 2'b01;
  - pattern 8 → 2'b11;
  - pattern 31 → 2'b10.
  - Inject a single-pattern mismatch at index 17: fail_count=1, first_fail=17.
- Reset and start handling:
  - rst asserted in APPLY of pattern 10: next cycle IDLE, all outputs at reset values.
  - A following start runs a full clean 32-pattern test.
  - start pulsed while busy: no effect.
- Restart and settle timing:
  - start in DONE restarts with cleared results.
  - At SETTLE=3, done rises exactly 128 cycles after busy rises.
